duel_round_ctrl: RTL and testbench

//  Round sequencer and checker arbiter for the two-player factorization duel.

---
 rtl/duel_round_ctrl_if.sv | 40 ++++
 rtl/duel_round_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_duel_round_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/duel_round_ctrl_if.sv
// Signal bundle between the duel round controller (master) and the buttons,
// question DB, answer checker and display (slave).
interface duel_round_ctrl_if #(
    parameter int HP_W  = 2,
    parameter int NUM_W = 4,
    parameter int SEC_W = 6
);
    // Every control line is a single-cycle pulse: start, sub1, sub2 and
    // chk_done from the slave; chk_req and q_load from the master.
    // A pulse means "act now", and no acknowledge is returned.
    // chk_ok qualifies chk_done. chk_sel stays stable for the whole CHECK state.
    logic             start;
    logic             sub1;
    logic             sub2;
    logic             chk_done;
    logic             chk_ok;
    logic             chk_req;
    logic             chk_sel;
    logic             q_load;
    logic [NUM_W-1:0] q_num;
    logic [2:0]       state;
    logic [HP_W-1:0]  hp1;
    logic [HP_W-1:0]  hp2;
    logic [SEC_W-1:0] sec_left;
    logic             lock1;
    logic             lock2;
    logic [1:0]       winner;

    modport master (
        input  start, sub1, sub2, chk_done, chk_ok,
        output chk_req, chk_sel, q_load, q_num, state,
               hp1, hp2, sec_left, lock1, lock2, winner
    );

    modport slave (
        output start, sub1, sub2, chk_done, chk_ok,
        input  chk_req, chk_sel, q_load, q_num, state,
               hp1, hp2, sec_left, lock1, lock2, winner
    );
endinterface

// File: rtl/duel_round_ctrl.sv
// Round sequencer and checker arbiter for the two-player factorization duel.
// Optional macro DUEL_PENALTY_EN: a wrong answer also costs the submitter one HP.
module duel_round_ctrl #(
    parameter int HP_INIT   = 3,
    parameter int HP_W      = 2,
    parameter int NUM_W     = 4,
    parameter int TICK_DIV  = 50_000_000,
    parameter int ROUND_SEC = 30,
    parameter int SEC_W     = 6,
    parameter int HOLD_CYC  = 100_000_000
) (
    input  logic                clk,
    input  logic                rst,
    duel_round_ctrl_if.master   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYC - 1);
    localparam logic [HP_W-1:0]  HP_FULL    = HP_W'(HP_INIT);
    localparam logic [SEC_W-1:0] SEC_FULL   = SEC_W'(ROUND_SEC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PLAY   = 3'd2,
        S_CHECK  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [HP_W-1:0]  hp1_q, hp1_d, hp2_q, hp2_d;
    logic [NUM_W-1:0] q_num_q, q_num_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             lock1_q, lock1_d, lock2_q, lock2_d;
    logic [1:0]       winner_q, winner_d;
    logic             prio_q, prio_d;
    logic             chk_sel_q, chk_sel_d;
    logic             chk_req_q, chk_req_d;

    logic req1, req2, grant, grant_p2, tick, timeout, verdict, start_ok;
    logic hold_done, other_locked, penalty_kill;

    function automatic logic [HP_W-1:0] dec_sat(input logic [HP_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // Shared decode used by both the next-state and the datapath logic.
    always_comb begin
        req1         = bus.sub1 && !lock1_q;
        req2         = bus.sub2 && !lock2_q;
        grant        = (state_q == S_PLAY) && (req1 || req2);
        grant_p2     = req2 && (!req1 || prio_q);
        tick         = (state_q == S_PLAY) && (presc_q == PRESC_LAST);
        timeout      = tick && (sec_q == SEC_W'(1)) && !grant;
        verdict      = (state_q == S_CHECK) && bus.chk_done;
        start_ok     = ((state_q == S_IDLE) || (state_q == S_OVER)) && bus.start;
        hold_done    = (hold_q == HOLD_LAST);
        other_locked = chk_sel_q ? lock1_q : lock2_q;
`ifdef DUEL_PENALTY_EN
        penalty_kill = chk_sel_q ? (hp2_q <= HP_W'(1)) : (hp1_q <= HP_W'(1));
`else
        penalty_kill = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start_ok) state_d = S_LOAD;
            S_LOAD:         state_d = S_PLAY;
            S_PLAY: begin
                if (grant)        state_d = S_CHECK;
                else if (timeout) state_d = S_RESULT;
            end
            S_CHECK: begin
                if (verdict) begin
                    if (bus.chk_ok || penalty_kill || other_locked) state_d = S_RESULT;
                    else                                             state_d = S_PLAY;
                end
            end
            S_RESULT: begin
                if (hold_done) state_d = ((hp1_q == '0) || (hp2_q == '0)) ? S_OVER : S_LOAD;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.state    = state_q;
        bus.q_load   = (state_q == S_LOAD);
        bus.q_num    = q_num_q;
        bus.chk_req  = chk_req_q;
        bus.chk_sel  = chk_sel_q;
        bus.hp1      = hp1_q;
        bus.hp2      = hp2_q;
        bus.sec_left = sec_q;
        bus.lock1    = lock1_q;
        bus.lock2    = lock2_q;
        bus.winner   = winner_q;
    end

    // Datapath next values; CHECK leaves prescaler and seconds untouched.
    always_comb begin
        hp1_d     = hp1_q;
        hp2_d     = hp2_q;
        q_num_d   = q_num_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        lock1_d   = lock1_q;
        lock2_d   = lock2_q;
        winner_d  = winner_q;
        prio_d    = prio_q;
        chk_sel_d = chk_sel_q;
        chk_req_d = grant;
        hold_d    = ((state_q == S_RESULT) && !hold_done) ? hold_q + 1'b1 : '0;

        if (start_ok) begin
            hp1_d    = HP_FULL;
            hp2_d    = HP_FULL;
            winner_d = 2'b00;
        end

        if (state_q == S_LOAD) begin
            q_num_d = q_num_q + 1'b1;
            lock1_d = 1'b0;
            lock2_d = 1'b0;
            sec_d   = SEC_FULL;
            presc_d = '0;
        end

        if (state_q == S_PLAY) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            // A grant in the same cycle swallows the second tick.
            if (tick && !grant) sec_d = sec_q - 1'b1;
            if (timeout) begin
                hp1_d = dec_sat(hp1_q);
                hp2_d = dec_sat(hp2_q);
            end
            if (grant) begin
                chk_sel_d = grant_p2;
                prio_d    = ~prio_q;
            end
        end

        if (verdict) begin
            if (bus.chk_ok) begin
                if (chk_sel_q) hp1_d = dec_sat(hp1_q);
                else           hp2_d = dec_sat(hp2_q);
            end else begin
                if (chk_sel_q) lock2_d = 1'b1;
                else           lock1_d = 1'b1;
`ifdef DUEL_PENALTY_EN
                if (chk_sel_q) hp2_d = dec_sat(hp2_q);
                else           hp1_d = dec_sat(hp1_q);
`endif
            end
        end

        if ((state_q == S_RESULT) && hold_done) begin
            if ((hp1_q == '0) && (hp2_q == '0)) winner_d = 2'b11;
            else if (hp2_q == '0)               winner_d = 2'b01;
            else if (hp1_q == '0)               winner_d = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp1_q     <= '0;
            hp2_q     <= '0;
            q_num_q   <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            hold_q    <= '0;
            lock1_q   <= 1'b0;
            lock2_q   <= 1'b0;
            winner_q  <= 2'b00;
            prio_q    <= 1'b0;
            chk_sel_q <= 1'b0;
            chk_req_q <= 1'b0;
        end else begin
            hp1_q     <= hp1_d;
            hp2_q     <= hp2_d;
            q_num_q   <= q_num_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            hold_q    <= hold_d;
            lock1_q   <= lock1_d;
            lock2_q   <= lock2_d;
            winner_q  <= winner_d;
            prio_q    <= prio_d;
            chk_sel_q <= chk_sel_d;
            chk_req_q <= chk_req_d;
        end
    end

endmodule

// File: tb/tb_duel_round_ctrl.sv
// Directed bench for duel_round_ctrl with small timing parameters.
module tb_duel_round_ctrl;

  localparam int HP_W  = 2;
  localparam int NUM_W = 2;
  localparam int SEC_W = 6;

`ifdef DUEL_PENALTY_EN
  localparam logic [HP_W-1:0] EXP_HP_WRONG = 2'd1;
`else
  localparam logic [HP_W-1:0] EXP_HP_WRONG = 2'd2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  duel_round_ctrl_if #(.HP_W(HP_W), .NUM_W(NUM_W), .SEC_W(SEC_W)) bus ();

  duel_round_ctrl #(
    .HP_INIT(2), .HP_W(HP_W), .NUM_W(NUM_W), .TICK_DIV(4),
    .ROUND_SEC(3), .SEC_W(SEC_W), .HOLD_CYC(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    bus.start = 0; bus.sub1 = 0; bus.sub2 = 0; bus.chk_done = 0; bus.chk_ok = 0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    step();
  endtask

  // START pulse, LOAD cycle, then one more edge to land in PLAY.
  task automatic start_to_play();
    bus.start = 1; step(); bus.start = 0;
    step();
  endtask

  task automatic pulse_sub(input logic s1, input logic s2);
    bus.sub1 = s1; bus.sub2 = s2; step(); bus.sub1 = 0; bus.sub2 = 0;
  endtask

  task automatic pulse_done(input logic ok);
    bus.chk_done = 1; bus.chk_ok = ok; step(); bus.chk_done = 0; bus.chk_ok = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", bus.state); end
    n_tests++; if ({bus.hp1, bus.hp2} !== 4'd0) begin n_fail++; $display("FAIL reset_hp: got %0d/%0d exp 0/0", bus.hp1, bus.hp2); end
    n_tests++; if ({bus.q_num, bus.sec_left, bus.winner} !== 10'd0) begin n_fail++; $display("FAIL reset_regs: q_num %0d sec %0d winner %0d exp 0", bus.q_num, bus.sec_left, bus.winner); end
    n_tests++; if ({bus.chk_req, bus.chk_sel, bus.q_load, bus.lock1, bus.lock2} !== 5'd0) begin n_fail++; $display("FAIL reset_flags: got %b exp 00000", {bus.chk_req, bus.chk_sel, bus.q_load, bus.lock1, bus.lock2}); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.start = 1; step(); bus.start = 0;
    n_tests++; if (bus.state !== 3'd1 || bus.q_load !== 1'b1 || bus.q_num !== 2'd0) begin n_fail++; $display("FAIL load0: state %0d q_load %b q_num %0d exp 1 1 0", bus.state, bus.q_load, bus.q_num); end
    n_tests++; if (bus.hp1 !== 2'd2 || bus.hp2 !== 2'd2) begin n_fail++; $display("FAIL start_hp: got %0d/%0d exp 2/2", bus.hp1, bus.hp2); end
    step();
    n_tests++; if (bus.state !== 3'd2 || bus.sec_left !== 6'd3 || bus.q_load !== 1'b0) begin n_fail++; $display("FAIL play_entry: state %0d sec %0d q_load %b exp 2 3 0", bus.state, bus.sec_left, bus.q_load); end
    steps(11);
    n_tests++; if (bus.state !== 3'd2 || bus.sec_left !== 6'd1) begin n_fail++; $display("FAIL play_11: state %0d sec %0d exp 2 1", bus.state, bus.sec_left); end
    step();
    n_tests++; if (bus.state !== 3'd4 || bus.sec_left !== 6'd0) begin n_fail++; $display("FAIL timeout: state %0d sec %0d exp 4 0", bus.state, bus.sec_left); end
    n_tests++; if (bus.hp1 !== 2'd1 || bus.hp2 !== 2'd1) begin n_fail++; $display("FAIL timeout_hp: got %0d/%0d exp 1/1", bus.hp1, bus.hp2); end
    steps(2);
    n_tests++; if (bus.state !== 3'd1 || bus.q_load !== 1'b1 || bus.q_num !== 2'd1) begin n_fail++; $display("FAIL load1: state %0d q_load %b q_num %0d exp 1 1 1", bus.state, bus.q_load, bus.q_num); end
  endtask

  task automatic test_single_correct();
    do_reset();
    start_to_play();
    pulse_sub(1, 0);
    n_tests++; if (bus.state !== 3'd3 || bus.chk_req !== 1'b1 || bus.chk_sel !== 1'b0) begin n_fail++; $display("FAIL grant_p1: state %0d req %b sel %b exp 3 1 0", bus.state, bus.chk_req, bus.chk_sel); end
    step();
    n_tests++; if (bus.state !== 3'd3 || bus.chk_req !== 1'b0) begin n_fail++; $display("FAIL req_pulse: state %0d req %b exp 3 0", bus.state, bus.chk_req); end
    pulse_done(1);
    n_tests++; if (bus.state !== 3'd4 || bus.hp2 !== 2'd1 || bus.hp1 !== 2'd2) begin n_fail++; $display("FAIL p1_hit: state %0d hp %0d/%0d exp 4 2/1", bus.state, bus.hp1, bus.hp2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_to_play();
    pulse_sub(1, 1);
    n_tests++; if (bus.state !== 3'd3 || bus.chk_sel !== 1'b0) begin n_fail++; $display("FAIL tie1_sel: state %0d sel %b exp 3 0", bus.state, bus.chk_sel); end
    pulse_done(1);
    n_tests++; if (bus.hp2 !== 2'd1 || bus.hp1 !== 2'd2) begin n_fail++; $display("FAIL tie1_hp: got %0d/%0d exp 2/1", bus.hp1, bus.hp2); end
    steps(3);
    n_tests++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL round2_play: got %0d exp 2", bus.state); end
    pulse_sub(1, 1);
    n_tests++; if (bus.chk_req !== 1'b1 || bus.chk_sel !== 1'b1) begin n_fail++; $display("FAIL tie2_sel: req %b sel %b exp 1 1", bus.chk_req, bus.chk_sel); end
    pulse_done(1);
    n_tests++; if (bus.state !== 3'd4 || bus.hp1 !== 2'd1 || bus.hp2 !== 2'd1) begin n_fail++; $display("FAIL tie2_hp: state %0d hp %0d/%0d exp 4 1/1", bus.state, bus.hp1, bus.hp2); end
  endtask

  task automatic test_lockout();
    do_reset();
    start_to_play();
    pulse_sub(0, 1);
    n_tests++; if (bus.chk_sel !== 1'b1) begin n_fail++; $display("FAIL p2_sel: got %b exp 1", bus.chk_sel); end
    pulse_done(0);
    n_tests++; if (bus.state !== 3'd2 || bus.lock2 !== 1'b1 || bus.lock1 !== 1'b0) begin n_fail++; $display("FAIL p2_wrong: state %0d locks %b%b exp 2 01", bus.state, bus.lock1, bus.lock2); end
    n_tests++; if (bus.hp2 !== EXP_HP_WRONG) begin n_fail++; $display("FAIL p2_wrong_hp: got %0d exp %0d", bus.hp2, EXP_HP_WRONG); end
    pulse_sub(0, 1);
    n_tests++; if (bus.state !== 3'd2 || bus.chk_req !== 1'b0) begin n_fail++; $display("FAIL locked_sub: state %0d req %b exp 2 0", bus.state, bus.chk_req); end
    pulse_sub(1, 0);
    n_tests++; if (bus.state !== 3'd3 || bus.chk_sel !== 1'b0) begin n_fail++; $display("FAIL p1_grant: state %0d sel %b exp 3 0", bus.state, bus.chk_sel); end
    pulse_done(0);
    n_tests++; if (bus.state !== 3'd4 || bus.lock1 !== 1'b1) begin n_fail++; $display("FAIL both_wrong: state %0d lock1 %b exp 4 1", bus.state, bus.lock1); end
    n_tests++; if (bus.hp1 !== EXP_HP_WRONG || bus.hp2 !== EXP_HP_WRONG) begin n_fail++; $display("FAIL both_wrong_hp: got %0d/%0d exp %0d/%0d", bus.hp1, bus.hp2, EXP_HP_WRONG, EXP_HP_WRONG); end
  endtask

  task automatic test_game_over();
    do_reset();
    start_to_play();
    pulse_sub(1, 0);
    pulse_done(1);
    steps(3);
    pulse_sub(1, 0);
    pulse_done(1);
    n_tests++; if (bus.state !== 3'd4 || bus.hp2 !== 2'd0 || bus.hp1 !== 2'd2) begin n_fail++; $display("FAIL ko_hp: state %0d hp %0d/%0d exp 4 2/0", bus.state, bus.hp1, bus.hp2); end
    steps(2);
    n_tests++; if (bus.state !== 3'd5 || bus.winner !== 2'b01) begin n_fail++; $display("FAIL over: state %0d winner %b exp 5 01", bus.state, bus.winner); end
    pulse_sub(1, 1);
    n_tests++; if (bus.state !== 3'd5 || bus.chk_req !== 1'b0) begin n_fail++; $display("FAIL over_sub: state %0d req %b exp 5 0", bus.state, bus.chk_req); end
    bus.start = 1; step(); bus.start = 0;
    n_tests++; if (bus.state !== 3'd1 || bus.hp1 !== 2'd2 || bus.hp2 !== 2'd2 || bus.winner !== 2'b00) begin n_fail++; $display("FAIL restart: state %0d hp %0d/%0d winner %b exp 1 2/2 00", bus.state, bus.hp1, bus.hp2, bus.winner); end
    n_tests++; if (bus.q_num !== 2'd2) begin n_fail++; $display("FAIL restart_qnum: got %0d exp 2", bus.q_num); end
  endtask

  task automatic test_abort();
    do_reset();
    start_to_play();
    pulse_sub(0, 1);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.state !== 3'd0 || bus.chk_sel !== 1'b0) begin n_fail++; $display("FAIL async_rst: state %0d sel %b exp 0 0", bus.state, bus.chk_sel); end
    step();
    rst = 1'b0;
    pulse_done(1);
    n_tests++; if (bus.state !== 3'd0 || {bus.hp1, bus.hp2} !== 4'd0) begin n_fail++; $display("FAIL late_done: state %0d hp %0d/%0d exp 0 0/0", bus.state, bus.hp1, bus.hp2); end
    n_tests++; if ({bus.q_num, bus.sec_left, bus.winner} !== 10'd0 || {bus.chk_req, bus.chk_sel, bus.q_load, bus.lock1, bus.lock2} !== 5'd0) begin n_fail++; $display("FAIL abort_regs: q_num %0d sec %0d flags %b exp 0 0 00000", bus.q_num, bus.sec_left, {bus.chk_req, bus.chk_sel, bus.q_load, bus.lock1, bus.lock2}); end
    // The aborted grant toggled priority; reset must bring it back to P1.
    start_to_play();
    pulse_sub(1, 1);
    n_tests++; if (bus.state !== 3'd3 || bus.chk_sel !== 1'b0) begin n_fail++; $display("FAIL prio_reset: state %0d sel %b exp 3 0", bus.state, bus.chk_sel); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_single_correct();
    test_back_to_back();
    test_lockout();
    test_game_over();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
